// File: rtl/spi_flash_arbiter.sv
// Shares one SPI flash port between instruction-fetch (I) and data-load (D)
// readers. Each grant runs a 64-bit mode-0 transfer: a 32-bit read command out,
// then a 32-bit word in. Build option SPI_FLASH_RR_EN selects round-robin on
// simultaneous requests; otherwise D has fixed priority over I.
module spi_flash_arbiter #(
  parameter int unsigned CLK_DIV = 2,
  parameter logic [7:0]  RD_OP   = 8'h03
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        i_req,
  input  logic [23:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [23:0] d_addr,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        busy,
  output logic        spi_clk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [7:0] DivReload = 8'(CLK_DIV - 1);
  // DONE plus GAP span 2*CLK_DIV cycles, so the next grant lands 2*CLK_DIV
  // cycles after the ack and CS stays high for at least 2*CLK_DIV+1 cycles.
  localparam logic [8:0] GapReload = 9'(2 * CLK_DIV - 2);

  typedef enum logic [1:0] {StIdle, StShift, StDone, StGap} state_e;

  state_e      state_q, state_d;
  logic [31:0] cmd_q, cmd_d;
  logic [31:0] sh_q, sh_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic [6:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  div_q, div_d;
  logic [8:0]  gap_q, gap_d;
  logic        sclk_q, sclk_d;
  logic        cs_n_q, cs_n_d;
  logic        mosi_q, mosi_d;
  logic        i_ack_q, i_ack_d;
  logic        d_ack_q, d_ack_d;
  logic        win_d_q, win_d_d;        // 1: D owns the current transfer
  logic        last_grant_q, last_grant_d;  // 1: D was granted last

  logic grant;
  logic pick_d;

  // Arbitration; a grant can only happen in IDLE and never while in reset.
  always_comb begin
    grant  = (state_q == StIdle) && (i_req || d_req) && RESET;
`ifdef SPI_FLASH_RR_EN
    if (i_req && d_req) begin
      pick_d = ~last_grant_q;
    end else begin
      pick_d = d_req;
    end
`else
    pick_d = d_req;
`endif
  end

  // Next-state logic for the transfer FSM and its datapath.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    sh_d         = sh_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    bitcnt_d     = bitcnt_q;
    div_d        = div_q;
    gap_d        = gap_q;
    sclk_d       = sclk_q;
    cs_n_d       = cs_n_q;
    mosi_d       = mosi_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    win_d_d      = win_d_q;
    last_grant_d = last_grant_q;

    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d      = StShift;
          win_d_d      = pick_d;
          last_grant_d = pick_d;
          cmd_d        = {RD_OP, pick_d ? d_addr : i_addr};
          mosi_d       = RD_OP[7];
          cs_n_d       = 1'b0;
          sclk_d       = 1'b0;
          bitcnt_d     = 7'd0;
          div_d        = DivReload;
        end
      end
      StShift: begin
        if (div_q == 8'd0) begin
          div_d = DivReload;
          if (!sclk_q) begin
            // Rising edge: capture miso.
            sclk_d = 1'b1;
            sh_d   = {sh_q[30:0], spi_miso};
          end else begin
            // Falling edge: end of a bit.
            sclk_d = 1'b0;
            if (bitcnt_q == 7'd63) begin
              state_d = StDone;
              cs_n_d  = 1'b1;
              mosi_d  = 1'b0;
              if (win_d_q) begin
                d_rdata_d = sh_q;
                d_ack_d   = 1'b1;
              end else begin
                i_rdata_d = sh_q;
                i_ack_d   = 1'b1;
              end
            end else begin
              bitcnt_d = bitcnt_q + 7'd1;
              // Zeros shift in behind the command, so bits 32..63 send 0.
              cmd_d    = {cmd_q[30:0], 1'b0};
              mosi_d   = cmd_q[30];
            end
          end
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      StDone: begin
        state_d = StGap;
        gap_d   = GapReload;
      end
      StGap: begin
        if (gap_q == 9'd0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - 9'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!RESET) begin
      state_q      <= StIdle;
      cmd_q        <= 32'h0;
      sh_q         <= 32'h0;
      i_rdata_q    <= 32'h0;
      d_rdata_q    <= 32'h0;
      bitcnt_q     <= 7'd0;
      div_q        <= 8'd0;
      gap_q        <= 9'd0;
      sclk_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      mosi_q       <= 1'b0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      win_d_q      <= 1'b0;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      sh_q         <= sh_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      bitcnt_q     <= bitcnt_d;
      div_q        <= div_d;
      gap_q        <= gap_d;
      sclk_q       <= sclk_d;
      cs_n_q       <= cs_n_d;
      mosi_q       <= mosi_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      win_d_q      <= win_d_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign busy     = (state_q != StIdle) || grant;
  assign i_ack    = i_ack_q;
  assign d_ack    = d_ack_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign spi_clk  = sclk_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Scoreboard bench for spi_flash_arbiter: randomized request scenarios, a
// flash model on the SPI pins, and a monitor comparing each ack against the
// expected port, cycle and data. A second instance checks CLK_DIV=1.
module tb_spi_flash_arbiter;

  localparam int unsigned CD  = 2;
  localparam int unsigned LAT = 1 + 128 * CD;

  logic        clk = 1'b0;
  logic        RESET = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0;
  logic [23:0] i_addr = '0, d_addr = '0;
  logic        i_ack, d_ack, busy, spi_clk, spi_cs_n, spi_mosi;
  logic        spi_miso = 1'b0;
  logic [31:0] i_rdata, d_rdata;

  logic        i1_req = 1'b0, d1_req = 1'b0;
  logic [23:0] i1_addr = '0, d1_addr = '0;
  logic        i1_ack, d1_ack, busy1, spi1_clk, spi1_cs_n, spi1_mosi;
  logic        spi1_miso = 1'b0;
  logic [31:0] i1_rdata, d1_rdata;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  spi_flash_arbiter #(.CLK_DIV(CD), .RD_OP(8'h03)) u_dut (
    .clk(clk), .RESET(RESET),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_ack(d_ack), .d_rdata(d_rdata),
    .busy(busy), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  spi_flash_arbiter #(.CLK_DIV(1), .RD_OP(8'h03)) u_dut1 (
    .clk(clk), .RESET(RESET),
    .i_req(i1_req), .i_addr(i1_addr), .i_ack(i1_ack), .i_rdata(i1_rdata),
    .d_req(d1_req), .d_addr(d1_addr), .d_ack(d1_ack), .d_rdata(d1_rdata),
    .busy(busy1), .spi_clk(spi1_clk), .spi_cs_n(spi1_cs_n), .spi_mosi(spi1_mosi),
    .spi_miso(spi1_miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Flash contents as a pure function of the byte address.
  function automatic logic [31:0] flash_word(input logic [23:0] a);
    if (a == 24'h000040) return 32'hDEADBEEF;
    return {a[7:0] ^ 8'hA5, a[23:16], a[15:8] + 8'h3C, ~a[7:0]};
  endfunction

  // Flash model for instance 0: collects the command, then serves the word.
  int          f0_cnt = 0;
  logic [31:0] f0_cmd = '0, f0_word = '0, f0_last = '0;
  always @(negedge spi_cs_n or posedge spi_clk) begin
    if (spi_clk === 1'b1 && spi_cs_n === 1'b0) begin
      if (f0_cnt < 32) f0_cmd = {f0_cmd[30:0], spi_mosi};
      f0_cnt++;
      if (f0_cnt == 32) begin
        f0_last = f0_cmd;
        f0_word = flash_word(f0_cmd[23:0]);
        check("flash_opcode", 64'(f0_cmd[31:24]), 64'h03);
      end
      spi_miso = (f0_cnt >= 32 && f0_cnt < 64) ? f0_word[63 - f0_cnt] : 1'b0;
    end else begin
      f0_cnt   = 0;
      spi_miso = 1'b0;
    end
  end

  // Flash model for the CLK_DIV=1 instance.
  int          f1_cnt = 0;
  logic [31:0] f1_cmd = '0, f1_word = '0, f1_last = '0;
  always @(negedge spi1_cs_n or posedge spi1_clk) begin
    if (spi1_clk === 1'b1 && spi1_cs_n === 1'b0) begin
      if (f1_cnt < 32) f1_cmd = {f1_cmd[30:0], spi1_mosi};
      f1_cnt++;
      if (f1_cnt == 32) begin
        f1_last = f1_cmd;
        f1_word = flash_word(f1_cmd[23:0]);
      end
      spi1_miso = (f1_cnt >= 32 && f1_cnt < 64) ? f1_word[63 - f1_cnt] : 1'b0;
    end else begin
      f1_cnt    = 0;
      spi1_miso = 1'b0;
    end
  end

  // Scoreboard entries and reference-model state.
  typedef struct {
    bit          is_d;
    logic [23:0] addr;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  bit          lg_d = 1'b0;          // model of last grant (1: D)
  logic [31:0] mi = '0, md = '0;     // model of held rdata per port

  function automatic bit pick(input bit pi, input bit pd);
`ifdef SPI_FLASH_RR_EN
    if (pi && pd) return !lg_d;
`endif
    return pd;
  endfunction

  // Monitor: every ack is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (i_ack || d_ack) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ack: got i_ack=%0b d_ack=%0b expected none (cycle %0d)",
                 i_ack, d_ack, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ack_port", 64'({i_ack, d_ack}), e.is_d ? 64'h1 : 64'h2);
        check("ack_cycle", 64'(cyc), 64'(e.cyc));
        if (e.is_d) begin
          md = flash_word(e.addr);
          check("d_rdata", 64'(d_rdata), 64'(md));
          check("i_rdata_held", 64'(i_rdata), 64'(mi));
        end else begin
          mi = flash_word(e.addr);
          check("i_rdata", 64'(i_rdata), 64'(mi));
          check("d_rdata_held", 64'(d_rdata), 64'(md));
        end
      end
    end
  end

  task automatic wait_idle();
    int lim;
    lim = cyc + 4 * LAT;
    @(negedge clk);
    while (busy !== 1'b0) begin
      if (cyc > lim) begin
        timeout("wait_idle");
        return;
      end
      @(negedge clk);
    end
  endtask

  // kind 0: I only, 1: D only, 2: both (each dropped on its ack),
  // 3: both held for four transactions.
  task automatic scenario(input int kind, input logic [23:0] ai, input logic [23:0] ad,
                          input int drop_at);
    int t0, g, need, got, lim;
    bit pi, pd, w;
    wait_idle();
    pi     = (kind != 1);
    pd     = (kind != 0);
    i_addr = ai;
    d_addr = ad;
    i_req  = pi;
    d_req  = pd;
    t0     = cyc;
    need   = (kind == 3) ? 4 : (kind == 2) ? 2 : 1;
    g      = t0;
    for (int k = 0; k < need; k++) begin
      w    = pick(pi, pd);
      lg_d = w;
      exp_q.push_back('{w, w ? ad : ai, g + int'(LAT)});
      if (kind == 2) begin
        if (w) pd = 1'b0;
        else pi = 1'b0;
      end
      g = g + int'(LAT) + 2 * int'(CD);
    end
    got = 0;
    lim = t0 + need * int'(LAT + 2 * CD) + 20;
    while (got < need) begin
      @(negedge clk);
      if (kind < 2 && cyc == t0 + 1) begin
        // Address is only sampled at the grant.
        if (kind == 1) d_addr = 24'($urandom);
        else i_addr = 24'($urandom);
      end
      if (kind < 2 && cyc == t0 + drop_at) begin
        i_req = 1'b0;
        d_req = 1'b0;
      end
      if (i_ack || d_ack) begin
        got++;
        if (kind != 3) begin
          if (i_ack) i_req = 1'b0;
          if (d_ack) d_req = 1'b0;
        end
      end
      if (got == need) begin
        i_req = 1'b0;
        d_req = 1'b0;
      end
      if (cyc > lim) begin
        timeout("scenario_acks");
        i_req = 1'b0;
        d_req = 1'b0;
        exp_q.delete();
        break;
      end
    end
  endtask

  initial begin
    int t0, lim;
    bit seen;

    // Reset held for three cycles with requests asserted.
    i_req = 1'b1;
    d_req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_cs_n", 64'(spi_cs_n), 64'h1);
      check("rst_sclk", 64'(spi_clk), 64'h0);
      check("rst_mosi", 64'(spi_mosi), 64'h0);
      check("rst_acks", 64'({i_ack, d_ack}), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_rdata", 64'({i_rdata, d_rdata}), 64'h0);
      check("rst1_cs_n", 64'(spi1_cs_n), 64'h1);
    end
    i_req = 1'b0;
    d_req = 1'b0;
    RESET = 1'b1;

    // Single instruction read of the known word.
    scenario(0, 24'h000040, 24'h0, 100000);
    check("cmd_0x40", 64'(f0_last), 64'h03000040);
    check("i_rdata_beef", 64'(i_rdata), 64'hDEADBEEF);

    // Simultaneous requests, then four held transactions.
    scenario(2, 24'h001234, 24'h00ABCC, 100000);
    scenario(3, 24'h100000, 24'h200004, 100000);

    // Randomized mix.
    for (int s = 0; s < 12; s++) begin
      scenario(int'($urandom_range(0, 3)), 24'($urandom), 24'($urandom),
               int'($urandom_range(1, LAT + 10)));
    end

    // Reset at bit 20 of a data read; the same request then completes.
    wait_idle();
    d_addr = 24'h0A0B0C;
    d_req  = 1'b1;
    t0     = cyc;
    lg_d   = 1'b1;
    while (cyc < t0 + 1 + 40 * int'(CD)) @(negedge clk);
    RESET = 1'b0;
    @(negedge clk);
    check("midrst_cs_n", 64'(spi_cs_n), 64'h1);
    check("midrst_sclk", 64'(spi_clk), 64'h0);
    check("midrst_busy", 64'(busy), 64'h0);
    check("midrst_rdata", 64'({i_rdata, d_rdata}), 64'h0);
    mi     = '0;
    md     = '0;
    RESET  = 1'b1;
    lg_d   = 1'b1;
    exp_q.push_back('{1'b1, 24'h0A0B0C, cyc + int'(LAT)});
    lim    = cyc + int'(LAT) + 20;
    seen   = 1'b0;
    while (!seen) begin
      @(negedge clk);
      if (d_ack) begin
        seen  = 1'b1;
        d_req = 1'b0;
      end else if (cyc > lim) begin
        timeout("after_reset_ack");
        d_req = 1'b0;
        exp_q.delete();
        break;
      end
    end

    // CLK_DIV=1 instance: spi_clk toggles every cycle, ack at T0+129.
    @(negedge clk);
    d1_addr = 24'hFFFFFC;
    d1_req  = 1'b1;
    t0      = cyc;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("div1_sclk", 64'(spi1_clk), 64'((k + 1) % 2));
      check("div1_cs_n", 64'(spi1_cs_n), 64'h0);
    end
    lim  = t0 + 200;
    seen = 1'b0;
    while (!seen) begin
      @(negedge clk);
      if (d1_ack) begin
        seen   = 1'b1;
        d1_req = 1'b0;
        check("div1_ack_cycle", 64'(cyc), 64'(t0 + 129));
        check("div1_rdata", 64'(d1_rdata), 64'(flash_word(24'hFFFFFC)));
        check("div1_cmd", 64'(f1_last), 64'h03FFFFFC);
      end else if (cyc > lim) begin
        timeout("div1_ack");
        d1_req = 1'b0;
        break;
      end
    end

    repeat (20) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
